// File: rtl/demux4_rr_dispatcher.sv
// Round-robin / fixed-destination dispatcher feeding four one-word lane buffers.
// A lane draining this cycle can take a new word on the same edge.
module demux4_rr_dispatcher #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          cfg_mode,
    input  logic [1:0]    cfg_dest,
    output logic [N-1:0]  z0,
    output logic [N-1:0]  z1,
    output logic [N-1:0]  z2,
    output logic [N-1:0]  z3,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [1:0]    sel,
    output logic [CW-1:0] xfer_cnt
);

    logic [N-1:0]  lane_q [4];
    logic [3:0]    valid_q;
    logic [3:0]    valid_d;
    logic [1:0]    ptr_q;
    logic [1:0]    sel_q;
    logic [CW-1:0] cnt_q;

    logic [3:0] lane_free;
    logic [3:0] load;
    logic [3:0] drain;
    logic [1:0] grant;
    logic [1:0] idx;
    logic       grant_vld;
    logic       accept;

    assign lane_free = ~valid_q | out_ready;

    // Walk from the farthest offset back to ptr so the nearest free lane wins.
    always_comb begin
        grant     = cfg_dest;
        grant_vld = 1'b0;
        idx       = 2'd0;
        if (cfg_mode) begin
            grant_vld = lane_free[cfg_dest];
        end else begin
            for (int i = 3; i >= 0; i--) begin
                idx = ptr_q + 2'(i);
                if (lane_free[idx]) begin
                    grant     = idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign in_ready = grant_vld;
    assign accept   = in_valid && grant_vld;
    assign load     = accept ? (4'b0001 << grant) : 4'b0000;
    assign drain    = valid_q & out_ready;
    assign valid_d  = (valid_q & ~drain) | load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                lane_q[k] <= '0;
            end
            valid_q <= 4'b0000;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    lane_q[k] <= in_data;
                end
            end
            valid_q <= valid_d;
            if (accept) begin
                sel_q <= grant;
                cnt_q <= cnt_q + CW'(1);
                if (!cfg_mode) begin
                    ptr_q <= grant + 2'd1;
                end
            end
        end
    end

    assign z0        = lane_q[0];
    assign z1        = lane_q[1];
    assign z2        = lane_q[2];
    assign z3        = lane_q[3];
    assign out_valid = valid_q;
    assign sel       = sel_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Scoreboard bench for demux4_rr_dispatcher: per-lane expected-word queues, a small
// grant/pointer model, and directed sequences for skip, fixed mode, wrap and async reset.
module tb_demux4_rr_dispatcher;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          cfg_mode;
    logic [1:0]    cfg_dest;
    logic [N-1:0]  z0, z1, z2, z3;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [1:0]    sel;
    logic [CW-1:0] xfer_cnt;

    always #5 clk = ~clk;

    demux4_rr_dispatcher #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_mode (cfg_mode),
        .cfg_dest (cfg_dest),
        .z0       (z0),
        .z1       (z1),
        .z2       (z2),
        .z3       (z3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel      (sel),
        .xfer_cnt (xfer_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [N-1:0]  lane_exp [4][$];
    logic [1:0]    m_ptr;
    logic [1:0]    m_sel;
    logic [3:0]    m_valid;
    logic [CW-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] lane_z(input int k);
        case (k)
            0:       return z0;
            1:       return z1;
            2:       return z2;
            default: return z3;
        endcase
    endfunction

    task automatic model_clear();
        m_ptr   = 2'd0;
        m_sel   = 2'd0;
        m_valid = 4'b0000;
        m_cnt   = '0;
        for (int k = 0; k < 4; k++) lane_exp[k].delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'b0000;
        cfg_mode  = 1'b0;
        cfg_dest  = 2'd0;
        model_clear();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_z0", 32'(z0), 32'h0);
        check("rst_z3", 32'(z3), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_cnt", 32'(xfer_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, predict grant, score drains, then check after the edge.
    task automatic step(input logic v, input logic [N-1:0] d, input logic mode,
                        input logic [1:0] dest, input logic [3:0] rdy);
        logic [3:0] free;
        logic [1:0] g;
        logic [1:0] cand;
        logic       gv;
        logic       acc;
        in_valid  = v;
        in_data   = d;
        cfg_mode  = mode;
        cfg_dest  = dest;
        out_ready = rdy;
        #1;
        free = ~m_valid | rdy;
        gv   = 1'b0;
        g    = dest;
        if (mode) begin
            gv = free[dest];
        end else begin
            for (int i = 0; i < 4; i++) begin
                cand = m_ptr + 2'(i);
                if (!gv && free[cand]) begin
                    g  = cand;
                    gv = 1'b1;
                end
            end
        end
        check("in_ready", 32'(in_ready), 32'(gv));
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && rdy[k]) begin
                check($sformatf("z%0d_drain", k), 32'(lane_z(k)), 32'(lane_exp[k].pop_front()));
                m_valid[k] = 1'b0;
            end
        end
        acc = v && gv;
        if (acc) begin
            m_valid[g] = 1'b1;
            lane_exp[g].push_back(d);
            m_sel = g;
            m_cnt = m_cnt + CW'(1);
            if (!mode) m_ptr = g + 2'd1;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("sel", 32'(sel), 32'(m_sel));
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        if (acc) check($sformatf("z%0d_load", g), 32'(lane_z(int'(g))), 32'(d));
        @(negedge clk);
    endtask

    logic [N-1:0] t1_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'b0000;
        cfg_mode  = 1'b0;
        cfg_dest  = 2'd0;
        model_clear();

        // Streaming round-robin with all consumers ready.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, t1_data[i], 1'b0, 2'd0, 4'hF);
        check("t1_cnt", 32'(xfer_cnt), 32'd5);
        check("t1_z0", 32'(z0), 32'h55);
        check("t1_sel", 32'(sel), 32'd0);

        // Back-pressure, then drain-through refill of lane 2.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, N'(8'h61 + i), 1'b0, 2'd0, 4'h0);
        check("t2_full_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'h65, 1'b0, 2'd0, 4'b0100);
        check("t2_z2", 32'(z2), 32'h65);
        check("t2_valid", 32'(out_valid), 32'hF);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);

        // Skip a held lane: lane 1 full with ptr at 1.
        do_reset();
        step(1'b1, 8'hA1, 1'b0, 2'd0, 4'hF);
        step(1'b1, 8'hA2, 1'b0, 2'd0, 4'hF);
        step(1'b1, 8'hA3, 1'b0, 2'd0, 4'b1101);
        step(1'b1, 8'hA4, 1'b0, 2'd0, 4'b1101);
        step(1'b1, 8'hA5, 1'b0, 2'd0, 4'b1101);
        step(1'b1, 8'hA6, 1'b0, 2'd0, 4'b1101);
        check("t3_skip_sel", 32'(sel), 32'd2);
        step(1'b1, 8'hA7, 1'b0, 2'd0, 4'b1101);
        check("t3_ptr3_sel", 32'(sel), 32'd3);
        check("t3_z1_held", 32'(z1), 32'hA2);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);

        // Fixed destination 3, blocked while lane 3 is full.
        do_reset();
        step(1'b1, 8'hA5, 1'b1, 2'd3, 4'b0111);
        step(1'b1, 8'h5A, 1'b1, 2'd3, 4'b0111);
        check("t4_blocked", 32'(in_ready), 32'd0);
        step(1'b1, 8'h5A, 1'b1, 2'd3, 4'b0111);
        check("t4_hold_z3", 32'(z3), 32'hA5);
        step(1'b1, 8'h5A, 1'b1, 2'd3, 4'hF);
        check("t4_z3_new", 32'(z3), 32'h5A);
        step(1'b1, 8'h77, 1'b0, 2'd0, 4'hF);
        check("t4_ptr_kept", 32'(sel), 32'd0);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);

        // Counter wrap at CW=4.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, N'($urandom_range(0, 255)), 1'b0, 2'd0, 4'hF);
        check("t5_wrap", 32'(xfer_cnt), 32'd1);

        // Asynchronous reset with lanes 0,1,3 occupied.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, N'(8'hB0 + i), 1'b0, 2'd0, 4'h0);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b0100);
        check("t6_pre_valid", 32'(out_valid), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'h0);
        check("t6_async_z0", 32'(z0), 32'h0);
        check("t6_async_z1", 32'(z1), 32'h0);
        check("t6_async_z3", 32'(z3), 32'h0);
        check("t6_async_sel", 32'(sel), 32'h0);
        check("t6_async_cnt", 32'(xfer_cnt), 32'h0);
        model_clear();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hC1, 1'b0, 2'd0, 4'hF);
        step(1'b1, 8'hC2, 1'b0, 2'd0, 4'hF);
        check("t6_after_sel", 32'(sel), 32'd1);
        check("t6_after_z0", 32'(z0), 32'hC1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
